mem_load_stage: RTL and testbench
=================================

Name: mem_load_stage

Overview:
- Parametrised successor of the blocking MEM pipeline stage.
- Sits between the M1 stage and WB. It accepts one instruction per handshake and waits for a split-transaction D-cache response (response may arrive any number of cycles later).
- Performs load byte/half/word alignment and sign extension. Holds the result across WB back-pressure, drops in-flight loads on flush, and drives the RF forwarding port with a readiness flag.

Parameters:
- RF_AW, 5, register-file address width.
- PC_W, 32, PC width carried on the bus.
- WAIT_MAX, 255, D-cache response timeout in cycles; counter width is clog2(WAIT_MAX+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- flush  in  1  exception/eret flush; kills the held instruction
- m1s_to_ms_valid  in  1  upstream valid
- ms_allowin  out  1  stage can accept this cycle
- m1s_to_ms_bus  in  PC_W+75  {ex, mem_op[2:0], res_from_mem, gr_we, dest[RF_AW-1:0], rt_value[31:0], alu_result[31:0], pc}
- dcache_rvalid  in  1  one-cycle D-cache read-data pulse
- dcache_rdata  in  32  read word (aligned, addr[1:0] ignored by cache)
- ws_allowin  in  1  WB accepts
- ms_to_ws_valid  out  1  result valid to WB
- ms_to_ws_bus  out  PC_W+39  {ex, gr_we, dest, final_result[31:0], pc}
- MEM_dest  out  RF_AW  forwarding destination; 0 when no valid instruction
- MEM_result  out  32  forwarding value
- MEM_fwd_ready  out  1  MEM_result is final (ID must stall on match while 0)
- ms_timeout  out  1  sticky error flag; cleared by reset only

Behaviour:
- Encodings: mem_op 0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LWL, 6=LWR, 7=reserved (treated as LW).
- State machine: IDLE, WAIT, DONE, DRAIN. Reset: IDLE, bus register 0, all outputs 0, ms_timeout 0.
- IDLE:
  - ms_allowin=1.
  - On m1s_to_ms_valid, capture the bus.
  - res_from_mem=1 and ex=0 -> WAIT.
  - Otherwise -> DONE with final_result=alu_result.
- WAIT:
  - ms_to_ws_valid=0, MEM_fwd_ready=0, ms_allowin=0.
  - On dcache_rvalid, compute the aligned result, latch it into the result register, and go to DONE. ms_to_ws_valid rises the next cycle (one cycle after the response).
- DONE:
  - ms_to_ws_valid=1, MEM_fwd_ready=1.
  - ms_allowin = ws_allowin (back-to-back: a new capture the same cycle WB takes the result).
  - If ws_allowin and no new valid -> IDLE.
  - If ws_allowin and new valid -> WAIT/DONE as from IDLE.
- flush:
  - In WAIT -> DRAIN.
  - In DONE -> IDLE.
  - In IDLE -> no capture.
  - Flush beats a simultaneous upstream valid.
- DRAIN:
  - ms_allowin=0 and ms_to_ws_valid=0 until dcache_rvalid; the response is discarded, then -> IDLE.
  - A response arriving in the same cycle as flush in WAIT is discarded and goes directly to IDLE.
- Timeout:
  - The counter clears on entering WAIT/DRAIN and increments each cycle there.
  - When it reaches WAIT_MAX: set ms_timeout, force final_result=0, and WAIT->DONE / DRAIN->IDLE.
- Alignment by a=alu_result[1:0]:
  - LB/LBU select byte a, sign- or zero-extended.
  - LH/LHU select the half at a[1]. a[0]=1 gives 0; the address error is flagged upstream.
  - LWL/LWR merge with rt_value per the MIPS little-endian rules.
- Forwarding:
  - MEM_dest = dest when state is WAIT or DONE and gr_we=1, else 0.
  - MEM_result = result register (DONE) or alu_result (IDLE).
- Reset asserted mid-WAIT returns the block to IDLE immediately. A later stray dcache_rvalid in IDLE is ignored.

Optional Feature:
- MS_LWLR_EN. Defined: mem_op 5/6 perform the unaligned LWL/LWR merge.
- Not defined: mem_op 5/6 behave as LW and rt_value is unused. The synthesiser removes the merge logic.

Decomposition:
- Shared package/header global_defines.vh: mem_op encodings, M1_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, state encodings.
- One sub-module, load_align: purely combinational (mem_op, addr[1:0], rdata, rt_value) -> 32-bit result, including the MS_LWLR_EN guard.

Test Plan:
- LB at addr ...1, rdata=0x1234_80FF, response 3 cycles later -> ms_to_ws_valid rises the cycle after the pulse; result 0xFFFF_FF80; MEM_fwd_ready 0 during WAIT.
- Non-load, alu_result=0x55, with ws_allowin held 0 for 4 cycles -> result held stable, ms_allowin=0. On release, the next instruction is captured the same cycle (no bubble).
- Flush during WAIT, response 2 cycles later -> no ms_to_ws_valid. ms_allowin returns to 1 the cycle after the response.
- LWL at a=1, rdata=0xAABB_CCDD, rt=0x1122_3344 -> 0xCCDD_3344 with MS_LWLR_EN; 0xAABB_CCDD without.
- No response for WAIT_MAX cycles -> ms_timeout=1, result 0 delivered, state returns to IDLE after WB accepts.
- LHU at a=2, rdata=0x8001_0000 -> 0x0000_8001; LH -> 0xFFFF_8001.

Source files
------------

// File: rtl/mem_load_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_load_stage_pkg
// Shared definitions for the MEM load stage: load operation encodings,
// stage state encodings and pipeline bus width helpers.
//
// Bus layouts:
//   M1 -> MS : {ex, mem_op[2:0], res_from_mem, gr_we, dest, rt_value[31:0],
//               alu_result[31:0], pc}
//   MS -> WS : {ex, gr_we, dest, final_result[31:0], pc}
// ---------------------------------------------------------------------------
package mem_load_stage_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LB  = 3'd1,
    OP_LBU = 3'd2,
    OP_LH  = 3'd3,
    OP_LHU = 3'd4,
    OP_LWL = 3'd5,
    OP_LWR = 3'd6,
    OP_RSV = 3'd7   // decodes as LW
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } ms_state_e;

  // ex + mem_op + res_from_mem + gr_we + dest + rt_value + alu_result + pc
  function automatic int m1_to_ms_bus_wd(input int pc_w, input int rf_aw);
    return pc_w + rf_aw + 70;
  endfunction

  // ex + gr_we + dest + final_result + pc
  function automatic int ms_to_ws_bus_wd(input int pc_w, input int rf_aw);
    return pc_w + rf_aw + 34;
  endfunction

  localparam int M1_TO_MS_BUS_WD = m1_to_ms_bus_wd(32, 5);
  localparam int MS_TO_WS_BUS_WD = ms_to_ws_bus_wd(32, 5);

endpackage

// File: rtl/mem_load_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load data alignment and extension.
//
// Ports:
//   mem_op   [2:0]  load type (mem_op_e encoding)
//   addr     [1:0]  low address bits of the load
//   rdata    [31:0] aligned word returned by the D-cache
//   rt_value [31:0] old destination value, merged by LWL/LWR
//   result   [31:0] value written back to the register file
//
// Build option: MS_LWLR_EN -- when defined, LWL/LWR perform the unaligned
// little-endian merge with rt_value; otherwise they decode as LW.
// ---------------------------------------------------------------------------
module load_align
  import mem_load_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_value,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // NOTE: every always_comb output gets a default first so that no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    sel_byte = rdata[7:0];
    unique case (addr)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
    endcase
  end

  assign sel_half = addr[1] ? rdata[31:16] : rdata[15:0];

`ifdef MS_LWLR_EN
  logic [31:0] lwl_val;
  logic [31:0] lwr_val;

  always_comb begin
    lwl_val = rdata;
    lwr_val = rdata;
    unique case (addr)
      2'd0: begin
        lwl_val = {rdata[7:0],  rt_value[23:0]};
        lwr_val = rdata;
      end
      2'd1: begin
        lwl_val = {rdata[15:0], rt_value[15:0]};
        lwr_val = {rt_value[31:24], rdata[31:8]};
      end
      2'd2: begin
        lwl_val = {rdata[23:0], rt_value[7:0]};
        lwr_val = {rt_value[31:16], rdata[31:16]};
      end
      2'd3: begin
        lwl_val = rdata;
        lwr_val = {rt_value[31:8], rdata[31:24]};
      end
    endcase
  end
`else
  // The merge is compiled out; rt_value is intentionally left unconsumed.
  logic unused_rt_value;
  assign unused_rt_value = ^rt_value;
`endif

  always_comb begin
    result = rdata;
    case (mem_op_e'(mem_op))
      OP_LB:  result = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU: result = {24'd0, sel_byte};
      // A misaligned half returns 0; the address error is raised upstream.
      OP_LH:  result = addr[0] ? 32'd0 : {{16{sel_half[15]}}, sel_half};
      OP_LHU: result = addr[0] ? 32'd0 : {16'd0, sel_half};
`ifdef MS_LWLR_EN
      OP_LWL: result = lwl_val;
      OP_LWR: result = lwr_val;
`endif
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_stage.sv
// ---------------------------------------------------------------------------
// mem_load_stage
// MEM pipeline stage between M1 and WB with a split-transaction D-cache.
// Accepts one instruction per handshake, waits for the cache response,
// aligns/extends load data, holds the result under WB back-pressure,
// drops in-flight loads on flush, and drives the RF forwarding port.
//
// Ports:
//   clk, reset (async, active high)
//   flush                      kill the held instruction
//   m1s_to_ms_valid / _bus     upstream instruction
//   ms_allowin                 stage can accept this cycle
//   dcache_rvalid / _rdata     one-cycle read response
//   ws_allowin                 WB accepts
//   ms_to_ws_valid / _bus      result to WB
//   MEM_dest / MEM_result      forwarding destination / value
//   MEM_fwd_ready              MEM_result is final
//   ms_timeout                 sticky response-timeout flag
//
// Build option: MS_LWLR_EN enables LWL/LWR merge (see load_align).
// ---------------------------------------------------------------------------
module mem_load_stage
  import mem_load_stage_pkg::*;
#(
  parameter int RF_AW    = 5,
  parameter int PC_W     = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic                                      m1s_to_ms_valid,
  output logic                                      ms_allowin,
  input  logic [m1_to_ms_bus_wd(PC_W, RF_AW)-1:0]   m1s_to_ms_bus,
  input  logic                                      dcache_rvalid,
  input  logic [31:0]                               dcache_rdata,
  input  logic                                      ws_allowin,
  output logic                                      ms_to_ws_valid,
  output logic [ms_to_ws_bus_wd(PC_W, RF_AW)-1:0]   ms_to_ws_bus,
  output logic [RF_AW-1:0]                          MEM_dest,
  output logic [31:0]                               MEM_result,
  output logic                                      MEM_fwd_ready,
  output logic                                      ms_timeout
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  // Upstream bus fields
  logic             in_ex;
  logic [2:0]       in_mem_op;
  logic             in_res_from_mem;
  logic             in_gr_we;
  logic [RF_AW-1:0] in_dest;
  logic [31:0]      in_rt_value;
  logic [31:0]      in_alu_result;
  logic [PC_W-1:0]  in_pc;

  assign {in_ex, in_mem_op, in_res_from_mem, in_gr_we, in_dest,
          in_rt_value, in_alu_result, in_pc} = m1s_to_ms_bus;

  // Held instruction
  ms_state_e        state_q, state_d;
  logic             ex_q;
  logic [2:0]       mem_op_q;
  logic             gr_we_q;
  logic [RF_AW-1:0] dest_q;
  logic [31:0]      rt_value_q;
  logic [31:0]      alu_result_q;
  logic [PC_W-1:0]  pc_q;
  logic [31:0]      result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;

  logic             capture;
  logic             load_result;
  logic             set_timeout;
  logic             cnt_hit;
  logic [31:0]      aligned;

  load_align u_load_align (
    .mem_op   (mem_op_q),
    .addr     (alu_result_q[1:0]),
    .rdata    (dcache_rdata),
    .rt_value (rt_value_q),
    .result   (aligned)
  );

  assign cnt_hit = (cnt_q == CNT_W'(WAIT_MAX));

  always_comb begin
    state_d        = state_q;
    result_d       = result_q;
    cnt_d          = '0;
    capture        = 1'b0;
    load_result    = 1'b0;
    set_timeout    = 1'b0;
    ms_allowin     = 1'b0;
    ms_to_ws_valid = 1'b0;
    MEM_fwd_ready  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ms_allowin = 1'b1;
        // Flush wins over a simultaneous upstream valid.
        if (m1s_to_ms_valid && !flush) capture = 1'b1;
      end
      S_WAIT: begin
        if (flush) begin
          // A response coinciding with the flush is consumed right here.
          state_d = dcache_rvalid ? S_IDLE : S_DRAIN;
        end else if (dcache_rvalid) begin
          state_d     = S_DONE;
          load_result = 1'b1;
          result_d    = aligned;
        end else if (cnt_hit) begin
          state_d     = S_DONE;
          load_result = 1'b1;
          result_d    = 32'd0;
          set_timeout = 1'b1;
        end
      end
      S_DONE: begin
        ms_to_ws_valid = 1'b1;
        MEM_fwd_ready  = 1'b1;
        ms_allowin     = ws_allowin;
        if (flush) begin
          state_d = S_IDLE;
        end else if (ws_allowin) begin
          state_d = S_IDLE;
          if (m1s_to_ms_valid) capture = 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcache_rvalid) begin
          state_d = S_IDLE;
        end else if (cnt_hit) begin
          state_d     = S_IDLE;
          set_timeout = 1'b1;
        end
      end
    endcase

    if (capture) begin
      state_d     = (in_res_from_mem && !in_ex) ? S_WAIT : S_DONE;
      load_result = 1'b1;
      result_d    = in_alu_result;
    end

    // Counter restarts on every entry to WAIT/DRAIN, counts while staying.
    if ((state_d == S_WAIT || state_d == S_DRAIN) && state_d == state_q)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge value; the bus register is reset too because
  // the outgoing bus must read as zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ex_q         <= 1'b0;
      mem_op_q     <= 3'd0;
      gr_we_q      <= 1'b0;
      dest_q       <= '0;
      rt_value_q   <= 32'd0;
      alu_result_q <= 32'd0;
      pc_q         <= '0;
      result_q     <= 32'd0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        ex_q         <= in_ex;
        mem_op_q     <= in_mem_op;
        gr_we_q      <= in_gr_we;
        dest_q       <= in_dest;
        rt_value_q   <= in_rt_value;
        alu_result_q <= in_alu_result;
        pc_q         <= in_pc;
      end
      if (load_result) result_q  <= result_d;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  assign ms_to_ws_bus = {ex_q, gr_we_q, dest_q, result_q, pc_q};
  assign MEM_dest     = ((state_q == S_WAIT || state_q == S_DONE) && gr_we_q)
                        ? dest_q : '0;
  assign MEM_result   = (state_q == S_DONE) ? result_q : alu_result_q;
  assign ms_timeout   = timeout_q;

endmodule

// File: tb/tb_mem_load_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_load_stage
// Directed bench for mem_load_stage with hand-computed expected values.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_mem_load_stage;

  localparam int RF_AW    = 5;
  localparam int PC_W     = 32;
  localparam int WAIT_MAX = 10;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 flush = 1'b0;
  logic                 m1s_to_ms_valid = 1'b0;
  logic                 ms_allowin;
  logic [PC_W+74:0]     m1s_to_ms_bus = '0;
  logic                 dcache_rvalid = 1'b0;
  logic [31:0]          dcache_rdata = 32'd0;
  logic                 ws_allowin = 1'b1;
  logic                 ms_to_ws_valid;
  logic [PC_W+38:0]     ms_to_ws_bus;
  logic [RF_AW-1:0]     MEM_dest;
  logic [31:0]          MEM_result;
  logic                 MEM_fwd_ready;
  logic                 ms_timeout;

  int errors = 0;
  int checks = 0;

  mem_load_stage #(.RF_AW(RF_AW), .PC_W(PC_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .m1s_to_ms_valid (m1s_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .m1s_to_ms_bus   (m1s_to_ms_bus),
    .dcache_rvalid   (dcache_rvalid),
    .dcache_rdata    (dcache_rdata),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .MEM_dest        (MEM_dest),
    .MEM_result      (MEM_result),
    .MEM_fwd_ready   (MEM_fwd_ready),
    .ms_timeout      (ms_timeout)
  );

  always #5 clk = ~clk;

  wire [31:0]   ws_result = ms_to_ws_bus[PC_W +: 32];
  wire [PC_W-1:0] ws_pc   = ms_to_ws_bus[PC_W-1:0];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PC_W+74:0] mk(input logic ex, input logic [2:0] op,
      input logic res, input logic we, input logic [4:0] dest,
      input logic [31:0] rt, input logic [31:0] alu, input logic [31:0] pc);
    return {ex, op, res, we, dest, rt, alu, pc};
  endfunction

  // Full load transaction from IDLE; response after `delay` WAIT cycles.
  task automatic do_load(input string tag, input logic [2:0] op,
      input logic [31:0] alu, input logic [31:0] rt, input logic [31:0] d,
      input int delay, input logic [31:0] exp);
    m1s_to_ms_valid = 1'b1;
    m1s_to_ms_bus   = mk(1'b0, op, 1'b1, 1'b1, 5'd9, rt, alu, 32'h300);
    tick();
    m1s_to_ms_valid = 1'b0;
    repeat (delay) begin
      check({tag, "_wait_valid"}, ms_to_ws_valid, 1'b0);
      tick();
    end
    dcache_rvalid = 1'b1;
    dcache_rdata  = d;
    tick();
    dcache_rvalid = 1'b0;
    check({tag, "_valid"}, ms_to_ws_valid, 1'b1);
    check({tag, "_result"}, ws_result, exp);
    tick();  // WB takes it
  endtask

  initial begin
    // ---------------- reset ----------------
    #2;
    check("rst_valid", ms_to_ws_valid, 1'b0);
    check("rst_bus", ms_to_ws_bus[31:0], 32'd0);
    check("rst_dest", MEM_dest, 5'd0);
    check("rst_fwd", MEM_fwd_ready, 1'b0);
    check("rst_timeout", ms_timeout, 1'b0);
    #10 reset = 1'b0;
    #1;
    check("idle_allowin", ms_allowin, 1'b1);

    // ---------------- LB at addr ...1, response 3 cycles later ----------------
    m1s_to_ms_valid = 1'b1;
    m1s_to_ms_bus   = mk(1'b0, 3'd1, 1'b1, 1'b1, 5'd3, 32'd0, 32'h1001, 32'h100);
    tick();
    m1s_to_ms_valid = 1'b0;
    check("lb_wait_valid", ms_to_ws_valid, 1'b0);
    check("lb_wait_fwd", MEM_fwd_ready, 1'b0);
    check("lb_wait_allowin", ms_allowin, 1'b0);
    check("lb_wait_dest", MEM_dest, 5'd3);
    tick();
    tick();
    dcache_rvalid = 1'b1;
    dcache_rdata  = 32'h1234_80FF;
    #1;
    check("lb_pulse_valid", ms_to_ws_valid, 1'b0);
    tick();
    dcache_rvalid = 1'b0;
    check("lb_done_valid", ms_to_ws_valid, 1'b1);
    check("lb_result", ws_result, 32'hFFFF_FF80);
    check("lb_fwd_ready", MEM_fwd_ready, 1'b1);
    check("lb_fwd_value", MEM_result, 32'hFFFF_FF80);
    tick();
    check("lb_idle_valid", ms_to_ws_valid, 1'b0);
    check("lb_idle_allowin", ms_allowin, 1'b1);

    // ---------------- non-load under back-pressure ----------------
    ws_allowin      = 1'b0;
    m1s_to_ms_valid = 1'b1;
    m1s_to_ms_bus   = mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd7, 32'd0, 32'h55, 32'h200);
    tick();
    m1s_to_ms_bus   = mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd8, 32'd0, 32'h66, 32'h204);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", ms_to_ws_valid, 1'b1);
      check("bp_result", ws_result, 32'h55);
      check("bp_pc", ws_pc, 32'h200);
      check("bp_allowin", ms_allowin, 1'b0);
      tick();
    end
    ws_allowin = 1'b1;
    #1;
    check("bp_release_allowin", ms_allowin, 1'b1);
    tick();
    m1s_to_ms_valid = 1'b0;
    check("b2b_valid", ms_to_ws_valid, 1'b1);
    check("b2b_result", ws_result, 32'h66);
    check("b2b_pc", ws_pc, 32'h204);
    tick();
    check("b2b_idle", ms_to_ws_valid, 1'b0);

    // ---------------- flush during WAIT ----------------
    m1s_to_ms_valid = 1'b1;
    m1s_to_ms_bus   = mk(1'b0, 3'd0, 1'b1, 1'b1, 5'd4, 32'd0, 32'h40, 32'h208);
    tick();
    m1s_to_ms_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("drain_valid", ms_to_ws_valid, 1'b0);
    check("drain_allowin", ms_allowin, 1'b0);
    check("drain_dest", MEM_dest, 5'd0);
    tick();
    dcache_rvalid = 1'b1;
    dcache_rdata  = 32'hDEAD_BEEF;
    #1;
    check("drain_resp_allowin", ms_allowin, 1'b0);
    tick();
    dcache_rvalid = 1'b0;
    check("drain_after_allowin", ms_allowin, 1'b1);
    check("drain_after_valid", ms_to_ws_valid, 1'b0);

    // flush together with response in WAIT -> straight to IDLE
    m1s_to_ms_valid = 1'b1;
    tick();
    m1s_to_ms_valid = 1'b0;
    flush = 1'b1;
    dcache_rvalid = 1'b1;
    tick();
    flush = 1'b0;
    dcache_rvalid = 1'b0;
    check("flush_resp_allowin", ms_allowin, 1'b1);
    check("flush_resp_valid", ms_to_ws_valid, 1'b0);

    // flush beats upstream valid in IDLE
    m1s_to_ms_valid = 1'b1;
    flush = 1'b1;
    tick();
    m1s_to_ms_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle_valid", ms_to_ws_valid, 1'b0);
    check("flush_idle_dest", MEM_dest, 5'd0);

    // flush in DONE under back-pressure -> IDLE
    ws_allowin      = 1'b0;
    m1s_to_ms_valid = 1'b1;
    m1s_to_ms_bus   = mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd7, 32'd0, 32'h77, 32'h20C);
    tick();
    m1s_to_ms_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ws_allowin = 1'b1;
    check("flush_done_valid", ms_to_ws_valid, 1'b0);
    check("flush_done_allowin", ms_allowin, 1'b1);

    // ---------------- alignment vectors ----------------
`ifdef MS_LWLR_EN
    do_load("lwl", 3'd5, 32'h2001, 32'h1122_3344, 32'hAABB_CCDD, 1, 32'hCCDD_3344);
    do_load("lwr", 3'd6, 32'h2002, 32'h1122_3344, 32'hAABB_CCDD, 0, 32'h1122_AABB);
`else
    do_load("lwl", 3'd5, 32'h2001, 32'h1122_3344, 32'hAABB_CCDD, 1, 32'hAABB_CCDD);
    do_load("lwr", 3'd6, 32'h2002, 32'h1122_3344, 32'hAABB_CCDD, 0, 32'hAABB_CCDD);
`endif
    do_load("lhu", 3'd4, 32'h2002, 32'd0, 32'h8001_0000, 2, 32'h0000_8001);
    do_load("lh",  3'd3, 32'h2002, 32'd0, 32'h8001_0000, 0, 32'hFFFF_8001);
    do_load("lh_odd", 3'd3, 32'h2001, 32'd0, 32'h8001_8001, 0, 32'h0000_0000);
    do_load("lbu", 3'd2, 32'h2003, 32'd0, 32'h9A00_0000, 1, 32'h0000_009A);
    do_load("lw",  3'd0, 32'h2000, 32'd0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D);
    do_load("rsv", 3'd7, 32'h2003, 32'd0, 32'h1357_9BDF, 0, 32'h1357_9BDF);

    // ---------------- timeout ----------------
    ws_allowin      = 1'b0;
    m1s_to_ms_valid = 1'b1;
    m1s_to_ms_bus   = mk(1'b0, 3'd0, 1'b1, 1'b1, 5'd2, 32'd0, 32'h3000, 32'h400);
    tick();
    m1s_to_ms_valid = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      tick();
      check("to_wait_valid", ms_to_ws_valid, 1'b0);
      check("to_wait_flag", ms_timeout, 1'b0);
    end
    tick();
    check("to_valid", ms_to_ws_valid, 1'b1);
    check("to_flag", ms_timeout, 1'b1);
    check("to_result", ws_result, 32'd0);
    ws_allowin = 1'b1;
    tick();
    check("to_idle_allowin", ms_allowin, 1'b1);
    check("to_idle_valid", ms_to_ws_valid, 1'b0);
    check("to_sticky", ms_timeout, 1'b1);

    // ---------------- reset mid-WAIT, stray response ----------------
    m1s_to_ms_valid = 1'b1;
    m1s_to_ms_bus   = mk(1'b0, 3'd0, 1'b1, 1'b1, 5'd6, 32'd0, 32'h44, 32'h500);
    tick();
    m1s_to_ms_valid = 1'b0;
    check("rw_dest", MEM_dest, 5'd6);
    reset = 1'b1;
    #1;
    check("rw_allowin", ms_allowin, 1'b1);
    check("rw_dest_clr", MEM_dest, 5'd0);
    check("rw_timeout_clr", ms_timeout, 1'b0);
    #2 reset = 1'b0;
    dcache_rvalid = 1'b1;
    dcache_rdata  = 32'hFFFF_FFFF;
    tick();
    dcache_rvalid = 1'b0;
    check("stray_valid", ms_to_ws_valid, 1'b0);
    check("stray_allowin", ms_allowin, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
